// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial-add scheduler: FSM encoding, requester
// indices and the round-robin pick used by the arbiter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic rr_pick(input logic r0, input logic r1, input logic last_id);
        if (r0 && r1) begin
            return ~last_id;
        end else if (r1) begin
            return REQ1;
        end else begin
            return REQ0;
        end
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial ripple adder datapath: operand shift registers, carry flop,
// partial-sum register and a down-counting bit counter.
module serial_add_core #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic         shift_en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] psum,
    output logic         carry,
    output logic         last_bit
);
    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]     qa;
    logic [N-1:0]     qb;
    logic [N-2:0]     psum_q;
    logic             carry_q;
    logic [CNT_W-1:0] count;
    logic             s_bit;

    // psum/carry present the values as they will be after the current shift
    // edge, so the scheduler can capture the finished result on the last one.
    assign s_bit    = qa[0] ^ qb[0] ^ carry_q;
    assign psum     = {s_bit, psum_q};
    assign carry    = (qa[0] & qb[0]) | (qa[0] & carry_q) | (qb[0] & carry_q);
    assign last_bit = shift_en && (count == CNT_W'(1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            qa      <= '0;
            qb      <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            count   <= '0;
        end else if (load) begin
            qa      <= a;
            qb      <= b;
            psum_q  <= '0;
            carry_q <= 1'b0;
            count   <= CNT_W'(N);
        end else if (shift_en) begin
            qa      <= {1'b0, qa[N-1:1]};
            qb      <= {1'b0, qb[N-1:1]};
            psum_q  <= psum[N-1:1];
            carry_q <= carry;
            count   <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// Shares one bit-serial adder between two req/ack requesters with
// round-robin arbitration and publishes each result with a done pulse.
//
//   state | meaning
//   IDLE  | arbitrate pending requests, load core on grant
//   LOAD  | ack pulse to granted requester
//   SHIFT | N serial add cycles
//   DONE  | done pulse, result registers newly valid
module serial_add_scheduler
    import serial_add_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         ack0,
    output logic         ack1,
    output logic         busy,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         done,
    output logic         done_id
);
    state_t       state;
    state_t       state_nxt;
    logic         gid;
    logic         last_id;
    logic         grant_id;
    logic         load;
    logic         shift_en;
    logic         ack0_nxt;
    logic         ack1_nxt;
    logic         done_nxt;
    logic [N-1:0] core_a;
    logic [N-1:0] core_b;
    logic [N-1:0] core_psum;
    logic         core_carry;
    logic         core_last;

    assign grant_id = rr_pick(req0, req1, last_id);
    assign core_a   = (grant_id == REQ1) ? a1 : a0;
    assign core_b   = (grant_id == REQ1) ? b1 : b0;

    serial_add_core #(.N(N)) u_core (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .shift_en (shift_en),
        .a        (core_a),
        .b        (core_b),
        .psum     (core_psum),
        .carry    (core_carry),
        .last_bit (core_last)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    load      = 1'b1;
                    ack0_nxt  = (grant_id == REQ0);
                    ack1_nxt  = (grant_id == REQ1);
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SHIFT;
            SHIFT: begin
                shift_en = 1'b1;
                if (core_last) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            done_id <= 1'b0;
            gid     <= 1'b0;
            last_id <= 1'b1;
        end else begin
            state <= state_nxt;
            ack0  <= ack0_nxt;
            ack1  <= ack1_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt != IDLE);
            if (load) begin
                gid     <= grant_id;
                last_id <= grant_id;
            end
            if (done_nxt) begin
                sum     <= core_psum;
                cout    <= core_carry;
                done_id <= gid;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench: tests queue expected results, monitors pop them on done.
module tb_serial_add_scheduler;

    typedef struct {
        logic       id;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1, busy, cout, done, done_id;
    logic [3:0] sum;

    logic       req8;
    logic [7:0] a8, b8;
    logic       ack8_0, ack8_1, busy8, cout8, done8, done_id8;
    logic [7:0] sum8;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack1_cnt = 0;
    int   done_cnt = 0;
    int   done8_cnt = 0;
    int   done8_cyc = 0;
    int   ack_at, ack_at_b, ack8_at;
    int   snap0, snap8;
    exp_t exp_q[$];
    exp_t exp8_q[$];
    int   done_cyc_q[$];
    exp_t e4, e8;

    serial_add_scheduler #(.N(4)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .sum(sum), .cout(cout), .done(done), .done_id(done_id)
    );

    serial_add_scheduler #(.N(8)) dut8 (
        .clock(clock), .resetn(resetn),
        .req0(req8), .a0(a8), .b0(b8),
        .req1(1'b0), .a1(8'd0), .b1(8'd0),
        .ack0(ack8_0), .ack1(ack8_1), .busy(busy8),
        .sum(sum8), .cout(cout8), .done(done8), .done_id(done_id8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    a_req0: assert property (@(posedge clock) disable iff (!resetn) (req0 && !ack0) |=> req0)
        else $error("req0 dropped before ack0");
    a_req1: assert property (@(posedge clock) disable iff (!resetn) (req1 && !ack1) |=> req1)
        else $error("req1 dropped before ack1");
    a_req8: assert property (@(posedge clock) disable iff (!resetn) (req8 && !ack8_0) |=> req8)
        else $error("req8 dropped before ack");

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (resetn && done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_id=%0d sum=%0d, required no done", done_id, sum);
            end else begin
                e4 = exp_q.pop_front();
                check("done_id", 32'(done_id), 32'(e4.id));
                check("sum", 32'(sum), 32'(e4.sum));
                check("cout", 32'(cout), 32'(e4.cout));
            end
        end
        if (ack1) ack1_cnt++;
    end

    always @(negedge clock) begin
        if (resetn && done8) begin
            done8_cnt++;
            done8_cyc = cyc;
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got sum=%0d, required no done", sum8);
            end else begin
                e8 = exp8_q.pop_front();
                check("sum8", 32'(sum8), 32'(e8.sum));
                check("cout8", 32'(cout8), 32'(e8.cout));
                check("done_id8", 32'(done_id8), 32'(e8.id));
            end
        end
    end

    function automatic exp_t mk(input logic id, input logic [7:0] s, input logic c);
        exp_t x;
        x.id = id;
        x.sum = s;
        x.cout = c;
        return x;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    // Present operands, hold req until ack, drop it on the edge that ends LOAD.
    task automatic serve(input logic id, input logic [3:0] a, input logic [3:0] b, output int at);
        int n;
        at = -1;
        n = 0;
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        while (at < 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if ((id && ack1) || (!id && ack0)) at = cyc;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack%0d_timeout: got no ack in 200 cycles, required ack", id);
        end else begin
            @(posedge clock);
            #1;
            check("ack_one_cycle", 32'(id ? ack1 : ack0), 32'd0);
        end
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 300) begin
            @(posedge clock);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", name, exp_q.size() + exp8_q.size());
        end
        #1;
    endtask

    initial begin
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        req8 = 0; a8 = 0; b8 = 0;
        do_reset();

        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_done_id", 32'(done_id), 0);

        // single request: 3+5
        ack1_cnt = 0;
        done_cyc_q.delete();
        exp_q.push_back(mk(1'b0, 8'd8, 1'b0));
        serve(1'b0, 4'd3, 4'd5, ack_at);
        wait_drain("single");
        check("single_latency", 32'(done_cyc_q[0] - ack_at), 32'd5);
        check("single_no_ack1", 32'(ack1_cnt), 0);

        // overflow from requester 1
        exp_q.push_back(mk(1'b1, 8'd0, 1'b1));
        exp_q.push_back(mk(1'b1, 8'd2, 1'b1));
        serve(1'b1, 4'd15, 4'd1, ack_at);
        serve(1'b1, 4'd9, 4'd9, ack_at);
        wait_drain("overflow");
        repeat (3) @(posedge clock);
        #1;
        check("hold_sum", 32'(sum), 32'd2);
        check("hold_cout", 32'(cout), 32'd1);

        // simultaneous requests after reset: req0 wins, then req1
        do_reset();
        done_cyc_q.delete();
        exp_q.push_back(mk(1'b0, 8'd3, 1'b0));
        exp_q.push_back(mk(1'b1, 8'd8, 1'b0));
        fork
            serve(1'b0, 4'd1, 4'd2, ack_at);
            serve(1'b1, 4'd4, 4'd4, ack_at_b);
        join
        wait_drain("simul");
        check("simul_spacing", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd7);

        // fairness: both held, grants alternate 0,1,0,1
        do_reset();
        exp_q.push_back(mk(1'b0, 8'd5, 1'b0));
        exp_q.push_back(mk(1'b1, 8'd0, 1'b1));
        exp_q.push_back(mk(1'b0, 8'd1, 1'b1));
        exp_q.push_back(mk(1'b1, 8'd13, 1'b0));
        fork
            begin
                serve(1'b0, 4'd2, 4'd3, ack_at);
                serve(1'b0, 4'd10, 4'd7, ack_at);
            end
            begin
                serve(1'b1, 4'd8, 4'd8, ack_at_b);
                serve(1'b1, 4'd12, 4'd1, ack_at_b);
            end
        join
        wait_drain("fair");

        // reset during the second shift cycle discards the operation
        serve(1'b0, 4'd5, 4'd3, ack_at);
        @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        check("abort_done_id", 32'(done_id), 0);
        snap0 = done_cnt;
        repeat (12) @(posedge clock);
        #1;
        check("abort_no_done", 32'(done_cnt - snap0), 0);
        exp_q.push_back(mk(1'b0, 8'd13, 1'b0));
        serve(1'b0, 4'd6, 4'd7, ack_at);
        wait_drain("after_abort");

        // N=8 instance: 200+100
        exp8_q.push_back(mk(1'b0, 8'd44, 1'b1));
        a8 = 8'd200;
        b8 = 8'd100;
        req8 = 1'b1;
        ack8_at = -1;
        for (int n = 0; n < 200 && ack8_at < 0; n++) begin
            @(posedge clock);
            #1;
            if (ack8_0) ack8_at = cyc;
        end
        if (ack8_at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack8_timeout: got no ack, required ack");
        end else begin
            @(posedge clock);
            #1;
        end
        req8 = 1'b0;
        wait_drain("n8");
        check("n8_latency", 32'(done8_cyc - ack8_at), 32'd9);

        // idle: nothing moves
        snap0 = done_cnt;
        snap8 = done8_cnt;
        repeat (20) @(posedge clock);
        #1;
        check("idle_busy", 32'(busy), 0);
        check("idle_busy8", 32'(busy8), 0);
        check("idle_done", 32'(done_cnt - snap0), 0);
        check("idle_done8", 32'(done8_cnt - snap8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
Sequences a bit-serial ripple adder and shares it between two requesters. Operands arrive on a level req/ack handshake, and a round-robin arbiter picks one requester. The block loads the operands, shifts them LSB-first through a one-bit full adder with a carry register for N cycles, then publishes the sum with a one-cycle done pulse. It sits between the operand sources and the downstream consumer of serial sums.

Parameters:
N, 4, operand/sum width in bits (N >= 2)
CNT_W, $clog2(N+1), width of the internal bit counter (derived; not overridden)

Ports:
clock  input  1  system clock; all state changes on rising edge
resetn  input  1  synchronous, active-low reset
req0  input  1  requester 0 operand valid; held with a0/b0 until ack0
a0  input  N  requester 0 operand A
b0  input  N  requester 0 operand B
req1  input  1  requester 1 operand valid; held with a1/b1 until ack1
a1  input  N  requester 1 operand A
b1  input  N  requester 1 operand B
ack0  output  1  one-cycle pulse: requester 0 operands accepted
ack1  output  1  one-cycle pulse: requester 1 operands accepted
busy  output  1  high in every state except IDLE
sum  output  N  (A+B) mod 2^N of the last completed operation
cout  output  1  carry out of the last completed operation
done  output  1  one-cycle pulse: sum/cout/done_id newly valid
done_id  output  1  requester index of the last completed operation

Behaviour:
- Reset: resetn is sampled only at the rising clock edge; there is no asynchronous path. When resetn=0 at an edge: state=IDLE, ack0/ack1/done/busy=0, sum=0, cout=0, done_id=0, carry=0, count=0, last_id=1 (requester 0 wins the first tie).
- Reset mid-operation: any in-flight operation is discarded. It produces no done, and its requester is not re-acked.
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester opposite to last_id.
  - On the grant edge: latch the selected a/b into the core shift registers, clear carry, set count=N, record gid, set last_id=gid, go to LOAD.
- LOAD: one cycle; ack[gid]=1 during it. Requesters drop req/operands on the edge that ends LOAD. Next state is SHIFT.
- SHIFT:
  - Each edge: s = qa[0]^qb[0]^carry and carry <= majority(qa[0],qb[0],carry).
  - qa/qb shift right with 0 fill; s shifts into the partial-sum register MSB. count decrements.
  - Leave when count reaches 0, after exactly N shift edges.
- SHIFT->DONE edge: sum <= partial-sum, cout <= final carry, done_id <= gid.
- DONE: one cycle; done=1. Next state is IDLE.
- Latency: the grant edge is t0. ack is high in cycle t0+1, and done is high in cycle t0+N+2.
- Throughput: one operation per N+3 cycles. Requests are not arbitrated outside IDLE; pending reqs wait and no ack is issued.
- A req that arrives during busy is served at the first IDLE cycle; arbitration runs in that cycle.
- Hold: sum/cout/done_id hold their values until the next done.
- Arithmetic: wrap-around is modulo 2^N and the overflow bit goes only to cout. No signed interpretation.
- A req dropped before its ack is protocol misuse; behaviour is undefined, and the bench flags it with an assertion.

Decomposition:
- Shared package serial_add_pkg: state encoding (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11) and requester indices REQ0=1'b0, REQ1=1'b1.
- Sub-module serial_add_core (parameter N), the datapath:
  - Inputs: clock, resetn, load, shift_en, a, b.
  - Contents: qa/qb shift registers, carry flop, partial-sum shift register, bit counter.
  - Outputs: psum, carry, last_bit (count==1 while shift_en).
- serial_add_scheduler contains the arbiter, FSM, handshake and result registers.

Test Plan:
- Single request, N=4: req0=1, a0=3, b0=5 -> ack0 one cycle later, done at t0+6, sum=8, cout=0, done_id=0, ack1 never asserted.
- Overflow, N=4: req1, a1=15, b1=1 -> sum=0, cout=1, done_id=1. Then a1=9, b1=9 -> sum=2, cout=1.
- Simultaneous requests after reset: req0 (a=1, b=2) and req1 (a=4, b=4) both high -> req0 served first (sum=3), then req1 (sum=8). The done pulses are exactly N+3 cycles apart.
- Fairness: req0 held continuously with new operands after each ack, req1 held -> grants alternate 0,1,0,1 over 4 operations.
- Reset mid-SHIFT: resetn=0 for one edge during the 2nd shift cycle -> no done, all outputs 0 the next cycle. A subsequent req0 with 6+7 gives sum=13, cout=0.
- N=8 parameter: a0=200, b0=100 -> sum=44, cout=1, done at t0+10. Idle with no reqs -> busy=0 and done never pulses.
